// File: rtl/dec_pkg.sv
// Shared constants and state type for the dec count sequencer
// and the one-hot select decoder it feeds.
package dec_pkg;

  localparam int CNT_W  = 8;
  localparam int PASS_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/dec_count_sequencer_if.sv
// Valid/ready code stream from the sequencer
// to the select decoder.
interface dec_count_sequencer_if
  import dec_pkg::*;
#(
  parameter int CNT_W = dec_pkg::CNT_W
);

  logic [CNT_W-1:0] count;
  logic             count_valid;
  logic             count_ready;

  modport master (
    output count,
    output count_valid,
    input  count_ready
  );

  modport slave (
    input  count,
    input  count_valid,
    output count_ready
  );

endinterface

// File: rtl/dec_count_sequencer.sv
// Sweeps [first..last] one code per handshake,
// one-shot or wrapping, with pass counting.
module dec_count_sequencer
  import dec_pkg::*;
#(
  parameter int CNT_W  = dec_pkg::CNT_W,
  parameter int PASS_W = dec_pkg::PASS_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  cfg_first,
  input  logic [CNT_W-1:0]  cfg_last,
  input  logic              cfg_wrap,
  dec_count_sequencer_if.master cif,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [PASS_W-1:0] passes
);

  state_e           state;
  state_e           state_nx;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] first_q;
  logic [CNT_W-1:0] last_q;
  logic             wrap_q;
  logic             hs;
  logic             at_last;
  logic             accept;
  logic             reject;
  logic             step;
  logic             finish;

  assign cif.count       = count_q;
  assign cif.count_valid = (state == RUN);
  assign busy            = (state == RUN);

  always_comb begin
    hs       = cif.count_valid & cif.count_ready;
    at_last  = (count_q == last_q);
    accept   = 1'b0;
    reject   = 1'b0;
    step     = 1'b0;
    finish   = 1'b0;
    state_nx = state;
    unique case (state)
      IDLE: begin
        accept = start & (cfg_first <= cfg_last);
        reject = start & (cfg_first > cfg_last);
        if (accept) state_nx = RUN;
      end
      RUN: begin
        // abort outranks a simultaneous handshake
        step   = hs & ~abort;
        finish = step & at_last & ~wrap_q;
        if (abort | finish) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      first_q <= '0;
      last_q  <= '0;
      wrap_q  <= 1'b0;
      passes  <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= finish;
      err  <= reject;
      unique case (1'b1)
        accept: begin
          first_q <= cfg_first;
          last_q  <= cfg_last;
          wrap_q  <= cfg_wrap;
          count_q <= cfg_first;
          passes  <= '0;
        end
        step: begin
          if (!at_last) begin
            count_q <= count_q + CNT_W'(1);
          end else begin
            if (wrap_q) count_q <= first_q;
            if (passes != '1) passes <= passes + PASS_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dec_count_sequencer.sv
// Directed plan plus random traffic checked each
// cycle against a behavioural sweep model.
module tb_dec_count_sequencer;
  import dec_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] cfg_first = '0;
  logic [7:0] cfg_last = '0;
  logic       cfg_wrap = 1'b0;
  logic       busy, done, err;
  logic [7:0] passes;

  dec_count_sequencer_if cif ();

  dec_count_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .cfg_first (cfg_first),
    .cfg_last  (cfg_last),
    .cfg_wrap  (cfg_wrap),
    .cif       (cif.master),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .passes    (passes)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: one sweep described by its range and progress
  bit m_run, m_wrap, m_done, m_err;
  int m_count, m_first, m_last, m_passes;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_run <= 0; m_wrap <= 0; m_done <= 0; m_err <= 0;
      m_count <= 0; m_first <= 0; m_last <= 0; m_passes <= 0;
    end else begin
      m_done <= 0;
      m_err  <= 0;
      if (!m_run) begin
        if (start && int'(cfg_first) > int'(cfg_last)) begin
          m_err <= 1;
        end else if (start) begin
          m_first <= cfg_first; m_last <= cfg_last;
          m_wrap <= cfg_wrap; m_count <= cfg_first;
          m_passes <= 0; m_run <= 1;
        end
      end else if (abort) begin
        m_run <= 0;
      end else if (cif.count_ready) begin
        if (m_count < m_last) begin
          m_count <= m_count + 1;
        end else begin
          m_passes <= (m_passes >= 255) ? 255 : m_passes + 1;
          if (m_wrap) m_count <= m_first;
          else begin m_run <= 0; m_done <= 1; end
        end
      end
    end
  end

  bit chk_on = 0;
  bit log_en = 0;
  int hs_log[$];

  always @(negedge clk) begin
    if (chk_on) begin
      chk("count", int'(cif.count), m_count);
      chk("count_valid", int'(cif.count_valid), int'(m_run));
      chk("busy", int'(busy), int'(m_run));
      chk("done", int'(done), int'(m_done));
      chk("err", int'(err), int'(m_err));
      chk("passes", int'(passes), m_passes);
      chk("done_err_excl", int'(done & err), 0);
    end
    if (log_en && cif.count_valid && cif.count_ready)
      hs_log.push_back(int'(cif.count));
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go(int f, int l, bit w);
    cfg_first = 8'(f); cfg_last = 8'(l); cfg_wrap = w;
    start = 1; cyc(1); start = 0;
  endtask

  int k;

  initial begin
    cif.count_ready = 1'b0;
    cyc(2);
    chk_on = 1;
    chk("rst_count", int'(cif.count), 0);
    chk("rst_valid", int'(cif.count_valid), 0);
    chk("rst_passes", int'(passes), 0);
    rst_n = 1;

    // 1: one-shot 5..8
    cif.count_ready = 1;
    go(5, 8, 0);
    chk("t1_first", int'(cif.count), 5);
    cyc(3);
    chk("t1_last", int'(cif.count), 8);
    cyc(1);
    chk("t1_done", int'(done), 1);
    chk("t1_valid", int'(cif.count_valid), 0);
    chk("t1_passes", int'(passes), 1);
    chk("t1_hold", int'(cif.count), 8);

    // 2: rejected range
    go(8'h0A, 8'h03, 0);
    chk("t2_err", int'(err), 1);
    chk("t2_valid", int'(cif.count_valid), 0);
    chk("t2_count", int'(cif.count), 8);
    cyc(1);
    chk("t2_err_clr", int'(err), 0);

    // 3: wrap FE..FF
    go(8'hFE, 8'hFF, 1);
    cyc(6);
    chk("t3_passes", int'(passes), 3);
    chk("t3_count", int'(cif.count), 8'hFE);
    abort = 1; cyc(1); abort = 0;

    // 4: back-pressured sweep 0..F
    hs_log.delete();
    log_en = 1;
    go(0, 15, 0);
    k = 0;
    while (!done && k < 200) begin
      cif.count_ready = (k % 4 == 0 || k % 4 == 3);
      cyc(1);
      k++;
    end
    log_en = 0;
    chk("t4_timeout", int'(k < 200), 1);
    chk("t4_len", hs_log.size(), 16);
    for (int i = 0; i < hs_log.size(); i++)
      chk("t4_order", hs_log[i], i);

    // 5: abort with handshake at 3
    cif.count_ready = 1;
    go(0, 8'h10, 0);
    cyc(3);
    chk("t5_at3", int'(cif.count), 3);
    abort = 1; cyc(1); abort = 0;
    chk("t5_valid", int'(cif.count_valid), 0);
    chk("t5_count", int'(cif.count), 3);
    chk("t5_done", int'(done), 0);
    go(2, 2, 0);
    chk("t5_restart", int'(cif.count), 2);
    cyc(1);
    chk("t5_single", int'(done), 1);

    // pass counter saturation on a single-code wrap
    go(8'h33, 8'h33, 1);
    cyc(300);
    chk("sat_passes", int'(passes), 255);
    abort = 1; cyc(1); abort = 0;

    // 6: reset mid-sweep at 0x40
    go(0, 8'hFF, 0);
    cyc(8'h40);
    chk("t6_at40", int'(cif.count), 8'h40);
    rst_n = 0; cyc(1);
    chk("t6_count", int'(cif.count), 0);
    chk("t6_valid", int'(cif.count_valid), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_passes", int'(passes), 0);
    chk("t6_done", int'(done), 0);
    rst_n = 1;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int f;
      f = int'($urandom_range(0, 255));
      cfg_first = 8'(f);
      if ($urandom_range(0, 7) == 0)
        cfg_last = 8'($urandom_range(0, 255));
      else
        cfg_last = 8'((f + int'($urandom_range(0, 6)) > 255) ?
                      255 : f + int'($urandom_range(0, 6)));
      cfg_wrap = 1'($urandom_range(0, 1));
      start = ($urandom_range(0, 5) == 0);
      abort = ($urandom_range(0, 40) == 0);
      cif.count_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 300) != 0);
      cyc(1);
    end
    start = 0; abort = 0; rst_n = 1;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
